// File: rtl/decode_pkg.sv
// Shared opcode constants and control decode for the decode/issue stage.
// Opcode groups follow the MIPS-like encoding in bits [31:26].
package decode_pkg;

    localparam logic [5:0] OP_RTYPE    = 6'h00;
    localparam logic [5:0] OP_ANDI     = 6'h0C;
    localparam logic [5:0] OP_ORI      = 6'h0D;
    localparam logic [5:0] OP_XORI     = 6'h0E;
    localparam logic [2:0] OP_IMM_GRP  = 3'b001;
    localparam logic [2:0] OP_LOAD_GRP = 3'b100;

    typedef struct packed {
        logic wr_en;
        logic mem_rd;
        logic zext;
        logic use_rd;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [5:0] op);
        ctrl_t c;
        c        = '0;
        c.use_rd = (op == OP_RTYPE);
        c.mem_rd = (op[5:3] == OP_LOAD_GRP);
        c.wr_en  = c.use_rd || (op[5:3] == OP_IMM_GRP) || c.mem_rd;
        c.zext   = (op == OP_ANDI) || (op == OP_ORI) || (op == OP_XORI);
        return c;
    endfunction

endpackage

// File: rtl/regfile_bypass.sv
// Two-read, one-write register file with same-cycle writeback bypass.
// Entry 0 reads as zero and ignores writes when ZERO_REG is set.
module regfile_bypass #(
    parameter int NBITS    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_en,
    input  logic [RW-1:0]    i_wb_sel,
    input  logic [NBITS-1:0] i_wb_data,
    input  logic [RW-1:0]    i_rd_a,
    input  logic [RW-1:0]    i_rd_b,
    output logic [NBITS-1:0] o_rd_a,
    output logic [NBITS-1:0] o_rd_b
);

    localparam bit ZR = (ZERO_REG != 0);

    logic [NBITS-1:0] r_regs [NREGS];
    logic             w_we;

    assign w_we = i_wb_en && (!ZR || (i_wb_sel != '0));

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (w_we) begin
            r_regs[i_wb_sel] <= i_wb_data;
        end
    end

    always_comb begin
        o_rd_a = r_regs[i_rd_a];
        if (w_we && (i_wb_sel == i_rd_a)) o_rd_a = i_wb_data;
        if (ZR && (i_rd_a == '0)) o_rd_a = '0;
    end

    always_comb begin
        o_rd_b = r_regs[i_rd_b];
        if (w_we && (i_wb_sel == i_rd_b)) o_rd_b = i_wb_data;
        if (ZR && (i_rd_b == '0)) o_rd_b = '0;
    end

endmodule

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: field decode, operand read, load-use interlock
// and the registered issue bundle toward execute.
module decode_issue_stage
    import decode_pkg::*;
#(
    parameter int NBITS    = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1,
    localparam int RW      = $clog2(NREGS)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_valid,
    input  logic [NBITS-1:0] i_pc,
    input  logic [NBITS-1:0] i_instr,
    output logic             o_ready,
    input  logic             i_wb_en,
    input  logic [RW-1:0]    i_wb_sel,
    input  logic [NBITS-1:0] i_wb_data,
    input  logic             i_flush,
    input  logic             i_ex_ready,
    output logic             o_valid,
    output logic [NBITS-1:0] o_pc,
    output logic [NBITS-1:0] o_rs_data,
    output logic [NBITS-1:0] o_rt_data,
    output logic [NBITS-1:0] o_imm,
    output logic [RW-1:0]    o_rs,
    output logic [RW-1:0]    o_rt,
    output logic [RW-1:0]    o_dst,
    output logic             o_reg_wr_en,
    output logic             o_mem_rd
);

    ctrl_t            w_ctrl;
    logic [RW-1:0]    w_rs, w_rt, w_rd, w_dst;
    logic [NBITS-1:0] w_rs_data, w_rt_data, w_imm;
    logic             w_hazard;

    assign w_ctrl = decode_ctrl(i_instr[31:26]);
    assign w_rs   = RW'(i_instr[25:21]);
    assign w_rt   = RW'(i_instr[20:16]);
    assign w_rd   = RW'(i_instr[15:11]);
    assign w_dst  = w_ctrl.use_rd ? w_rd : w_rt;
    assign w_imm  = w_ctrl.zext
                  ? {{(NBITS-16){1'b0}}, i_instr[15:0]}
                  : {{(NBITS-16){i_instr[15]}}, i_instr[15:0]};

    regfile_bypass #(
        .NBITS    (NBITS),
        .NREGS    (NREGS),
        .ZERO_REG (ZERO_REG)
    ) u_rf (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wb_en   (i_wb_en),
        .i_wb_sel  (i_wb_sel),
        .i_wb_data (i_wb_data),
        .i_rd_a    (w_rs),
        .i_rd_b    (w_rt),
        .o_rd_a    (w_rs_data),
        .o_rd_b    (w_rt_data)
    );

    // The bubble clears o_mem_rd, so a load can stall its consumer once only.
    assign w_hazard = o_valid && o_mem_rd && (o_dst != '0) && i_valid
                   && ((o_dst == w_rs) || (o_dst == w_rt));

    assign o_ready = i_ex_ready && !w_hazard;

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_valid     <= 1'b0;
            o_pc        <= '0;
            o_rs_data   <= '0;
            o_rt_data   <= '0;
            o_imm       <= '0;
            o_rs        <= '0;
            o_rt        <= '0;
            o_dst       <= '0;
            o_reg_wr_en <= 1'b0;
            o_mem_rd    <= 1'b0;
        end else if (i_flush) begin
            o_valid     <= 1'b0;
            o_reg_wr_en <= 1'b0;
            o_mem_rd    <= 1'b0;
        end else if (i_ex_ready) begin
            if (w_hazard || !i_valid) begin
                o_valid     <= 1'b0;
                o_reg_wr_en <= 1'b0;
                o_mem_rd    <= 1'b0;
            end else begin
                o_valid     <= 1'b1;
                o_pc        <= i_pc;
                o_rs_data   <= w_rs_data;
                o_rt_data   <= w_rt_data;
                o_imm       <= w_imm;
                o_rs        <= w_rs;
                o_rt        <= w_rt;
                o_dst       <= w_dst;
                o_reg_wr_en <= w_ctrl.wr_en;
                o_mem_rd    <= w_ctrl.mem_rd;
            end
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Randomised and directed checks of decode_issue_stage against a
// behavioural reference model.
module tb_decode_issue_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, i_wb_en, i_flush, i_ex_ready;
    logic [31:0] i_pc, i_instr, i_wb_data;
    logic [4:0]  i_wb_sel;
    logic        o_ready, o_valid, o_reg_wr_en, o_mem_rd;
    logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm;
    logic [4:0]  o_rs, o_rt, o_dst;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    decode_issue_stage dut (
        .i_clk       (clk),
        .i_rst       (rst_n),
        .i_valid     (i_valid),
        .i_pc        (i_pc),
        .i_instr     (i_instr),
        .o_ready     (o_ready),
        .i_wb_en     (i_wb_en),
        .i_wb_sel    (i_wb_sel),
        .i_wb_data   (i_wb_data),
        .i_flush     (i_flush),
        .i_ex_ready  (i_ex_ready),
        .o_valid     (o_valid),
        .o_pc        (o_pc),
        .o_rs_data   (o_rs_data),
        .o_rt_data   (o_rt_data),
        .o_imm       (o_imm),
        .o_rs        (o_rs),
        .o_rt        (o_rt),
        .o_dst       (o_dst),
        .o_reg_wr_en (o_reg_wr_en),
        .o_mem_rd    (o_mem_rd)
    );

    // reference model state
    logic [31:0] mreg [32];
    bit          m_valid, m_wr, m_mrd, m_known;
    logic [31:0] m_pc, m_rsd, m_rtd, m_imm;
    logic [4:0]  m_rs, m_rt, m_dst;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mread(input logic [4:0] idx);
        if (idx == 0) return 32'h0;
        if (i_wb_en && i_wb_sel == idx) return i_wb_data;
        return mreg[idx];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
        m_valid = 0; m_wr = 0; m_mrd = 0; m_known = 1;
        m_pc = 0; m_rsd = 0; m_rtd = 0; m_imm = 0;
        m_rs = 0; m_rt = 0; m_dst = 0;
    endtask

    task automatic set_in(input bit v, input logic [31:0] pc,
                          input logic [31:0] ins, input bit we,
                          input logic [4:0] sel, input logic [31:0] wd,
                          input bit fl, input bit exr);
        i_valid = v; i_pc = pc; i_instr = ins;
        i_wb_en = we; i_wb_sel = sel; i_wb_data = wd;
        i_flush = fl; i_ex_ready = exr;
    endtask

    // One clock: check o_ready, predict, clock, compare registered outputs.
    task automatic step();
        int op, rs, rt, rd;
        bit hz;
        #1;
        op = int'(i_instr[31:26]);
        rs = int'(i_instr[25:21]);
        rt = int'(i_instr[20:16]);
        rd = int'(i_instr[15:11]);
        hz = m_valid && m_mrd && m_dst != 0 && i_valid
             && (m_dst == rs || m_dst == rt);
        chk("ready", 64'(o_ready), 64'(i_ex_ready && !hz));
        if (i_flush) begin
            m_valid = 0; m_wr = 0; m_mrd = 0; m_known = 1;
        end else if (i_ex_ready) begin
            if (hz) begin
                m_valid = 0; m_wr = 0; m_mrd = 0; m_known = 1;
            end else if (!i_valid) begin
                m_valid = 0; m_known = 0;
            end else begin
                m_valid = 1; m_known = 1;
                m_pc  = i_pc;
                m_rsd = mread(5'(rs));
                m_rtd = mread(5'(rt));
                m_rs  = 5'(rs);
                m_rt  = 5'(rt);
                m_dst = (op == 0) ? 5'(rd) : 5'(rt);
                m_mrd = (op >= 32 && op <= 39);
                m_wr  = (op == 0) || (op >= 8 && op <= 15) || m_mrd;
                if (op == 12 || op == 13 || op == 14)
                    m_imm = {16'h0, i_instr[15:0]};
                else
                    m_imm = {{16{i_instr[15]}}, i_instr[15:0]};
            end
        end
        if (i_wb_en && i_wb_sel != 0) mreg[i_wb_sel] = i_wb_data;
        @(posedge clk);
        #1;
        chk("valid", 64'(o_valid), 64'(m_valid));
        if (m_valid) begin
            chk("pc", 64'(o_pc), 64'(m_pc));
            chk("rs_data", 64'(o_rs_data), 64'(m_rsd));
            chk("rt_data", 64'(o_rt_data), 64'(m_rtd));
            chk("imm", 64'(o_imm), 64'(m_imm));
            chk("idx", 64'({o_rs, o_rt, o_dst}), 64'({m_rs, m_rt, m_dst}));
        end
        if (m_valid || m_known)
            chk("ctl", 64'({o_reg_wr_en, o_mem_rd}), 64'({m_wr, m_mrd}));
    endtask

    initial begin
        logic [5:0] ops [10];
        logic [5:0] op;
        ops = '{6'h00, 6'h08, 6'h0C, 6'h0D, 6'h0E,
                6'h23, 6'h20, 6'h2B, 6'h04, 6'h3F};
        model_reset();
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out", 64'({o_valid, o_reg_wr_en, o_mem_rd, o_dst}), 64'h0);
        chk("rst_data", 64'({o_rs_data, o_pc}), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // write r5, then add rd=6 reading it
        set_in(0, 0, 0, 1, 5'd5, 32'h1234, 0, 1);
        step();
        set_in(1, 32'h100, 32'h00A53020, 0, 0, 0, 0, 1);
        step();
        chk("d31_rs", 64'(o_rs_data), 64'h1234);
        chk("d31_dst", 64'(o_dst), 64'd6);
        chk("d31_wr", 64'({o_valid, o_reg_wr_en}), 64'b11);

        // same-cycle writeback bypass
        set_in(1, 32'h104, 32'h00E04020, 1, 5'd7, 32'hCAFE, 0, 1);
        step();
        chk("d32_byp", 64'(o_rs_data), 64'hCAFE);

        // load-use interlock
        set_in(1, 32'h108, 32'h8C280004, 0, 0, 0, 0, 1);
        step();
        chk("d33_ld", 64'({o_mem_rd, o_dst}), 64'({1'b1, 5'd8}));
        set_in(1, 32'h10C, 32'h01004800, 0, 0, 0, 0, 1);
        #1;
        chk("d33_stall", 64'(o_ready), 64'd0);
        step();
        chk("d33_bub", 64'({o_valid, o_mem_rd}), 64'h0);
        step();
        chk("d33_iss", 64'({o_valid, o_dst}), 64'({1'b1, 5'd9}));

        // immediate extension
        set_in(1, 32'h110, 32'h34018000, 0, 0, 0, 0, 1);
        step();
        chk("d34_ori", 64'(o_imm), 64'h0000_8000);
        set_in(1, 32'h114, 32'h20018000, 0, 0, 0, 0, 1);
        step();
        chk("d34_addi", 64'(o_imm), 64'hFFFF_8000);

        // flush beats stall; r0 stays zero
        set_in(1, 32'h118, 32'h00A53020, 1, 5'd0, 32'hDEAD, 1, 0);
        step();
        chk("d35_fl", 64'(o_valid), 64'd0);
        set_in(1, 32'h11C, 32'h00000020, 0, 0, 0, 0, 1);
        step();
        chk("d35_r0", 64'({o_rs_data, o_rt_data}), 64'h0);

        for (int n = 0; n < 400; n++) begin
            op = ops[$urandom_range(0, 9)];
            set_in($urandom_range(0, 3) != 0, $urandom,
                   {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    16'($urandom)},
                   $urandom_range(0, 1) != 0, 5'($urandom_range(0, 7)),
                   $urandom, $urandom_range(0, 9) == 0,
                   $urandom_range(0, 3) != 0);
            step();
        end

        // reset asserted in the middle of a load-use stall
        set_in(1, 32'h200, 32'h8C280004, 1, 5'd8, 32'h55, 0, 1);
        step();
        set_in(1, 32'h204, 32'h01004800, 0, 0, 0, 0, 1);
        #1;
        chk("d36_stall", 64'(o_ready), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("d36_ctl", 64'({o_valid, o_reg_wr_en, o_mem_rd}), 64'h0);
        chk("d36_dat", 64'({o_pc, o_rs_data}), 64'h0);
        chk("d36_f2", 64'({o_rt_data, o_imm}), 64'h0);
        chk("d36_idx", 64'({o_rs, o_rt, o_dst}), 64'h0);
        model_reset();
        #3;
        rst_n = 1'b1;
        #1;
        chk("d36_rdy", 64'(o_ready), 64'(i_ex_ready));
        step();
        chk("d36_iss", 64'({o_valid, o_rs_data}), 64'({1'b1, 32'h0}));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 SHALL have parameter NBITS, default 32, meaning datapath and instruction width.
REQ-002 SHALL have parameter NREGS, default 32, meaning register count; index width RW = clog2(NREGS).
REQ-003 SHALL have parameter ZERO_REG, default 1, meaning register 0 is hardwired to zero when 1.
REQ-004 SHALL have ports: i_clk in 1 clock; i_rst in 1 asynchronous active-low reset.
REQ-005 SHALL have ports: i_valid in 1 fetch word valid; i_pc in NBITS; i_instr in NBITS; o_ready out 1 stage accepts word.
REQ-006 SHALL have ports: i_wb_en in 1; i_wb_sel in RW; i_wb_data in NBITS (writeback port).
REQ-007 SHALL have ports: i_flush in 1 squash; i_ex_ready in 1 downstream accepts.
REQ-008 SHALL have registered outputs: o_valid 1; o_pc, o_rs_data, o_rt_data, o_imm NBITS; o_rs, o_rt, o_dst RW; o_reg_wr_en 1; o_mem_rd 1.

Function
REQ-009 Decode SHALL use opcode = i_instr[31:26], rs = [25:21], rt = [20:16], rd = [15:11], imm = [15:0], truncated to RW bits.
REQ-010 Destination SHALL be rd when opcode = 0, else rt.
REQ-011 Reg write enable SHALL be 1 for opcode 0, 0x08-0x0F and loads (opcode[5:3] = 3'b100); else 0.
REQ-012 o_mem_rd SHALL be 1 only for loads.
REQ-013 Immediate SHALL zero-extend for opcodes 0x0C, 0x0D, 0x0E, sign-extend otherwise, to NBITS.
REQ-014 Register file SHALL write i_wb_data on i_clk rising edge when i_wb_en and (i_wb_sel != 0 or ZERO_REG = 0).
REQ-015 Reads SHALL bypass: if i_wb_en and i_wb_sel equals read index (and index non-zero under ZERO_REG), read data = i_wb_data same cycle.
REQ-016 With ZERO_REG = 1, reads of index 0 SHALL return 0.
REQ-017 Load-use hazard SHALL assert when o_valid, o_mem_rd, o_dst != 0, and o_dst equals incoming rs or rt, with i_valid.
REQ-018 o_ready SHALL equal i_ex_ready and not hazard (combinational).
REQ-019 Transfer SHALL occur when i_valid and o_ready; output register then loads the decoded word with o_valid = 1.
REQ-020 On hazard with i_ex_ready = 1, output register SHALL load a bubble: o_valid = 0, o_reg_wr_en = 0, o_mem_rd = 0; other fields don't care.
REQ-021 When i_ex_ready = 0, output register SHALL hold all fields.
REQ-022 When i_valid = 0 and i_ex_ready = 1, o_valid SHALL go 0 next cycle.
REQ-023 i_flush SHALL take priority: next cycle o_valid = 0, o_reg_wr_en = 0, o_mem_rd = 0 regardless of i_ex_ready or hazard.
REQ-024 Latency SHALL be one cycle from accepted word to o_valid.
REQ-025 Hazard SHALL stall at most one cycle per load since bubble clears o_mem_rd.

Reset
REQ-026 While i_rst = 0, all output register fields SHALL be 0 and all register file entries SHALL be 0.
REQ-027 Reset assertion mid-stall or mid-write SHALL abandon the operation; first cycle after release o_ready = i_ex_ready.

Structure
REQ-028 Opcode constants (R-type, ANDI, ORI, XORI, load group) SHALL live in a shared package decode_pkg.
REQ-029 Register file with bypass SHALL be one sub-module, regfile_bypass, parametrised by NBITS, NREGS, ZERO_REG.
REQ-030 Hazard detection and output register SHALL remain in decode_issue_stage.

Verification
REQ-031 Write r5 = 0x1234 via WB, decode 0x00A53020 (add rd=6) -> o_rs_data = 0x1234, o_dst = 6, o_reg_wr_en = 1, o_valid next cycle.
REQ-032 Same-cycle WB r7 = 0xCAFE and decode reading rs = 7 -> o_rs_data = 0xCAFE (bypass).
REQ-033 Load 0x8C280004 (lw rt=8) then instr with rs = 8 -> o_ready = 0 one cycle, one bubble, consumer issues next cycle.
REQ-034 ori imm 0x8000 -> o_imm = 0x00008000; addi imm 0x8000 -> o_imm = 0xFFFF8000.
REQ-035 i_flush together with valid transfer and i_ex_ready = 0 -> next cycle o_valid = 0; WB to r0 -> r0 reads 0.
REQ-036 Assert i_rst low mid-stall -> all outputs 0 immediately; after release o_ready = i_ex_ready, no bubble pending.
